// File: rtl/pipelined_add_sub.sv
// rtl/pipelined_add_sub.sv - pipelined chunked two's-complement adder/subtractor with carry and overflow flags
module pipelined_add_sub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             CB,
    output logic             OV
);
    // WIDTH must be an integer multiple of CHUNK; one slice is resolved per stage.
    localparam int STAGES = WIDTH / CHUNK;

    // Per-stage state. Operand registers hold the not-yet-added upper slices
    // shifted down, so the next slice to resolve always sits in the low CHUNK
    // bits. The result register collects finished slices from the top and
    // shifts them down, so after the last stage slice 0 lands at bit 0.
    logic [WIDTH-1:0]  r_a [STAGES];
    logic [WIDTH-1:0]  r_b [STAGES];
    logic [WIDTH-1:0]  r_y [STAGES];
    logic [STAGES-1:0] r_c;
    logic [STAGES-1:0] r_v;
    logic              r_ov;

    // Per-stage inputs (from the ports for stage 0, else from the previous stage).
    logic [WIDTH-1:0]  w_a_src [STAGES];
    logic [WIDTH-1:0]  w_b_src [STAGES];
    logic [WIDTH-1:0]  w_y_src [STAGES];
    logic [STAGES-1:0] w_c_src;
    logic [STAGES-1:0] w_v_src;

    // Per-stage next values.
    logic [CHUNK:0]    w_sum   [STAGES];
    logic [WIDTH-1:0]  w_a_nxt [STAGES];
    logic [WIDTH-1:0]  w_b_nxt [STAGES];
    logic [WIDTH-1:0]  w_y_nxt [STAGES];
    logic              w_ov;
    logic              w_adv;

    // The whole pipeline moves together unless a finished beat is stuck at the output.
    assign w_adv    = !r_v[STAGES-1] || out_ready;
    assign in_ready = w_adv;

    assign out_valid = r_v[STAGES-1];
    assign Y         = r_y[STAGES-1];
    assign CB        = r_c[STAGES-1];
    assign OV        = r_ov;

    // Route each stage's inputs: stage 0 takes the ports (B inverted and carry-in
    // set for subtraction), later stages take the previous stage's registers.
    always_comb begin
        w_c_src = '0;
        w_v_src = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_a_src[k] = '0;
            w_b_src[k] = '0;
            w_y_src[k] = '0;
        end
        w_a_src[0] = A;
        w_b_src[0] = sub ? ~B : B;
        w_y_src[0] = '0;
        w_c_src[0] = sub;
        w_v_src[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            w_a_src[k] = r_a[k-1];
            w_b_src[k] = r_b[k-1];
            w_y_src[k] = r_y[k-1];
            w_c_src[k] = r_c[k-1];
            w_v_src[k] = r_v[k-1];
        end
    end

    // Resolve one CHUNK-bit slice per stage and skew the remaining operand and
    // result bits forward; overflow is derived in the top stage from the MSB.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_sum[k]   = {1'b0, w_a_src[k][CHUNK-1:0]}
                       + {1'b0, w_b_src[k][CHUNK-1:0]}
                       + {{CHUNK{1'b0}}, w_c_src[k]};
            w_a_nxt[k] = w_a_src[k] >> CHUNK;
            w_b_nxt[k] = w_b_src[k] >> CHUNK;
            w_y_nxt[k] = WIDTH'({w_sum[k][CHUNK-1:0], w_y_src[k]} >> CHUNK);
        end
        // Carry into the MSB is a^b^sum at that bit; overflow is that XOR carry out.
        w_ov = w_a_src[STAGES-1][CHUNK-1] ^ w_b_src[STAGES-1][CHUNK-1]
             ^ w_sum[STAGES-1][CHUNK-1] ^ w_sum[STAGES-1][CHUNK];
    end

    // Pipeline registers: cleared on reset, advanced in lockstep on w_adv, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_y[k] <= '0;
            end
            r_c  <= '0;
            r_v  <= '0;
            r_ov <= 1'b0;
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= w_a_nxt[k];
                r_b[k] <= w_b_nxt[k];
                r_y[k] <= w_y_nxt[k];
                r_c[k] <= w_sum[k][CHUNK];
                r_v[k] <= w_v_src[k];
            end
            r_ov <= w_ov;
        end
    end
endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb/tb_pipelined_add_sub.sv - scoreboard testbench for pipelined_add_sub
module tb_pipelined_add_sub;
    localparam int STAGES0 = 32 / 8;
    localparam int STAGES1 = 16 / 4;
    localparam int STAGES2 = 8 / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        d0_in_valid, d0_in_ready, d0_sub, d0_out_valid, d0_out_ready, d0_cb, d0_ov;
    logic [31:0] d0_a, d0_b, d0_y;
    logic        d1_in_valid, d1_in_ready, d1_sub, d1_out_valid, d1_out_ready, d1_cb, d1_ov;
    logic [15:0] d1_a, d1_b, d1_y;
    logic        d2_in_valid, d2_in_ready, d2_sub, d2_out_valid, d2_out_ready, d2_cb, d2_ov;
    logic [7:0]  d2_a, d2_b, d2_y;

    pipelined_add_sub #(.WIDTH(32), .CHUNK(8)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(d0_in_valid), .in_ready(d0_in_ready),
        .A(d0_a), .B(d0_b), .sub(d0_sub), .out_valid(d0_out_valid),
        .out_ready(d0_out_ready), .Y(d0_y), .CB(d0_cb), .OV(d0_ov)
    );

    pipelined_add_sub #(.WIDTH(16), .CHUNK(4)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .A(d1_a), .B(d1_b), .sub(d1_sub), .out_valid(d1_out_valid),
        .out_ready(d1_out_ready), .Y(d1_y), .CB(d1_cb), .OV(d1_ov)
    );

    pipelined_add_sub #(.WIDTH(8), .CHUNK(8)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
        .A(d2_a), .B(d2_b), .sub(d2_sub), .out_valid(d2_out_valid),
        .out_ready(d2_out_ready), .Y(d2_y), .CB(d2_cb), .OV(d2_ov)
    );

    int checks = 0;
    int errors = 0;
    logic [33:0] exp_q[$];   // {CB, OV, Y zero-extended to 32 bits}

    // Reference: plain wide addition, overflow from operand/result sign bits.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input int w);
        logic [31:0] mask, am, be, y;
        logic [32:0] sum;
        logic        cb, ov;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        am   = a & mask;
        be   = (s ? ~b : b) & mask;
        sum  = {1'b0, am} + {1'b0, be} + {32'b0, s};
        y    = sum[31:0] & mask;
        cb   = sum[w];
        ov   = (am[w-1] == be[w-1]) && (y[w-1] != am[w-1]);
        return {cb, ov, y};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({d0_out_valid, d0_cb, d0_ov, d0_y} !== 35'b0) begin
            errors++;
            $display("FAIL reset_d0: got v=%b cb=%b ov=%b y=%h expected all zero",
                     d0_out_valid, d0_cb, d0_ov, d0_y);
        end
        checks++;
        if ({d1_out_valid, d2_out_valid, d1_y, d2_y} !== 26'b0) begin
            errors++;
            $display("FAIL reset_d1d2: got v1=%b v2=%b y1=%h y2=%h expected zero",
                     d1_out_valid, d2_out_valid, d1_y, d2_y);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (d0_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", d0_in_ready);
        end
    endtask

    task automatic single_beat(input logic [31:0] a, input logic [31:0] b, input logic s,
                               input string name);
        int lat;
        logic [33:0] exp, got;
        @(negedge clk);
        d0_a = a; d0_b = b; d0_sub = s; d0_in_valid = 1'b1; d0_out_ready = 1'b1;
        #1;
        checks++;
        if (d0_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_accept: in_ready got %b expected 1", name, d0_in_ready);
        end
        exp_q.push_back(model(a, b, s, 32));
        lat = 0;
        do begin
            @(negedge clk);
            d0_in_valid = 1'b0;
            lat++;
        end while (d0_out_valid !== 1'b1 && lat < 20);
        checks++;
        if (lat != STAGES0) begin
            errors++;
            $display("FAIL %s_latency: got %0d expected %0d", name, lat, STAGES0);
        end
        exp = exp_q.pop_front();
        got = {d0_cb, d0_ov, d0_y};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s_result: got cb=%b ov=%b y=%h expected cb=%b ov=%b y=%h",
                     name, got[33], got[32], got[31:0], exp[33], exp[32], exp[31:0]);
        end
    endtask

    task automatic test_stream();
        logic [31:0] sa, sb;
        logic        ss, stalled;
        logic [33:0] held, exp, got;
        int sent, rcvd, cyc, extra;
        sent = 0; rcvd = 0; cyc = 0; stalled = 1'b0; held = '0;
        sa = $urandom; sb = $urandom; ss = 1'($urandom_range(0, 1));
        while ((sent < 20 || rcvd < 20) && cyc < 300) begin
            @(negedge clk);
            d0_out_ready = ((cyc % 5) < 2);
            d0_in_valid  = (sent < 20);
            d0_a = sa; d0_b = sb; d0_sub = ss;
            #1;
            if (stalled) begin
                checks++;
                if ({d0_out_valid, d0_cb, d0_ov, d0_y} !== {1'b1, held}) begin
                    errors++;
                    $display("FAIL stream_hold: got v=%b %h expected v=1 %h",
                             d0_out_valid, {d0_cb, d0_ov, d0_y}, held);
                end
            end
            if (d0_out_valid && !d0_out_ready) begin
                checks++;
                if (d0_in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_stall_ready: in_ready got %b expected 0", d0_in_ready);
                end
                stalled = 1'b1;
                held = {d0_cb, d0_ov, d0_y};
            end else begin
                stalled = 1'b0;
            end
            if (d0_out_valid && d0_out_ready) begin
                checks++;
                got = {d0_cb, d0_ov, d0_y};
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra: got %h expected no beat", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL stream_beat%0d: got %h expected %h", rcvd, got, exp);
                    end
                end
                rcvd++;
            end
            if (d0_in_valid && d0_in_ready) begin
                exp_q.push_back(model(sa, sb, ss, 32));
                sent++;
                sa = $urandom; sb = $urandom; ss = 1'($urandom_range(0, 1));
            end
            cyc++;
        end
        d0_in_valid = 1'b0;
        checks++;
        if (rcvd != 20 || sent != 20 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stream_count: got sent=%0d rcvd=%0d left=%0d expected 20 20 0",
                     sent, rcvd, exp_q.size());
        end
        d0_out_ready = 1'b1;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (d0_out_valid) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL stream_dup: got %0d extra beats expected 0", extra);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int stale;
        d0_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            d0_a = $urandom; d0_b = $urandom; d0_sub = 1'(i & 1); d0_in_valid = 1'b1;
            #1;
            exp_q.push_back(model(d0_a, d0_b, d0_sub, 32));
        end
        @(negedge clk);
        d0_in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({d0_out_valid, d0_cb, d0_ov, d0_y} !== 35'b0) begin
            errors++;
            $display("FAIL midrst_clear: got v=%b cb=%b ov=%b y=%h expected all zero",
                     d0_out_valid, d0_cb, d0_ov, d0_y);
        end
        exp_q.delete();
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (d0_out_valid) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL midrst_stale: got %0d stale beats expected 0", stale);
        end
        single_beat(32'h1234_5678, 32'h0FED_CBA9, 1'b0, "midrst_next");
    endtask

    task automatic param_beat(input int sel, input logic [31:0] a, input logic [31:0] b,
                              input logic s, input string name);
        int lat, w, exp_lat;
        logic [33:0] exp, got;
        logic        ov_valid;
        w       = (sel == 1) ? 16 : 8;
        exp_lat = (sel == 1) ? STAGES1 : STAGES2;
        @(negedge clk);
        if (sel == 1) begin
            d1_a = a[15:0]; d1_b = b[15:0]; d1_sub = s; d1_in_valid = 1'b1; d1_out_ready = 1'b1;
        end else begin
            d2_a = a[7:0]; d2_b = b[7:0]; d2_sub = s; d2_in_valid = 1'b1; d2_out_ready = 1'b1;
        end
        #1;
        exp_q.push_back(model(a, b, s, w));
        lat = 0;
        do begin
            @(negedge clk);
            d1_in_valid = 1'b0;
            d2_in_valid = 1'b0;
            lat++;
            ov_valid = (sel == 1) ? d1_out_valid : d2_out_valid;
        end while (ov_valid !== 1'b1 && lat < 20);
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
        end
        got = (sel == 1) ? {d1_cb, d1_ov, 16'b0, d1_y} : {d2_cb, d2_ov, 24'b0, d2_y};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s_result: got cb=%b ov=%b y=%h expected cb=%b ov=%b y=%h",
                     name, got[33], got[32], got[31:0], exp[33], exp[32], exp[31:0]);
        end
    endtask

    task automatic test_params();
        param_beat(1, 32'h0000_00FF, 32'h0000_FF01, 1'b0, "w16_add");
        checks++;
        if ({d1_cb, d1_y} !== 17'h1_0000) begin
            errors++;
            $display("FAIL w16_const: got cb=%b y=%h expected cb=1 y=0000", d1_cb, d1_y);
        end
        param_beat(1, 32'h0000_8000, 32'h0000_0001, 1'b1, "w16_sub");
        param_beat(2, 32'h0000_007F, 32'h0000_0001, 1'b0, "w8_add");
        param_beat(2, 32'h0000_0000, 32'h0000_0001, 1'b1, "w8_sub");
    endtask

    initial begin
        rst = 1'b1;
        d0_in_valid = 1'b0; d0_a = '0; d0_b = '0; d0_sub = 1'b0; d0_out_ready = 1'b1;
        d1_in_valid = 1'b0; d1_a = '0; d1_b = '0; d1_sub = 1'b0; d1_out_ready = 1'b1;
        d2_in_valid = 1'b0; d2_a = '0; d2_b = '0; d2_sub = 1'b0; d2_out_ready = 1'b1;

        test_reset();
        single_beat(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "ripple");
        checks++;
        if ({d0_cb, d0_ov, d0_y} !== 34'h2_0000_0000) begin
            errors++;
            $display("FAIL ripple_const: got cb=%b ov=%b y=%h expected cb=1 ov=0 y=00000000",
                     d0_cb, d0_ov, d0_y);
        end
        single_beat(32'h0000_0005, 32'h0000_0007, 1'b1, "borrow");
        single_beat(32'h8000_0000, 32'h0000_0001, 1'b1, "sub_ov");
        single_beat(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "add_ov");
        checks++;
        if ({d0_cb, d0_ov, d0_y} !== 34'h1_8000_0000) begin
            errors++;
            $display("FAIL add_ov_const: got cb=%b ov=%b y=%h expected cb=0 ov=1 y=80000000",
                     d0_cb, d0_ov, d0_y);
        end
        test_stream();
        test_reset_mid();
        test_params();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipelined_add_sub.md
Name: pipelined_add_sub

Overview:
Parametrised, pipelined two's-complement adder/subtractor, the successor to the 32-bit combinational ripple adder. The operand width is split into CHUNK-bit slices, and each pipeline stage resolves one slice, so the carry chain per cycle is only CHUNK bits long. A valid/ready handshake on both sides allows backpressure. The block sits in the datapath wherever a registered add/sub with carry and overflow flags is needed at clock rate.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK.
CHUNK, 8, bits resolved per pipeline stage; STAGES = WIDTH/CHUNK (default 4).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand beat offered.
in_ready  output  1  block accepts the beat this cycle.
A  input  WIDTH  operand A.
B  input  WIDTH  operand B.
sub  input  1  0: Y=A+B; 1: Y=A-B (computed as A+~B+1).
out_valid  output  1  result beat available.
out_ready  input  1  downstream accepts the result.
Y  output  WIDTH  sum/difference, modulo 2^WIDTH.
CB  output  1  carry out of the MSB. For sub, 1 means no borrow (A>=B unsigned).
OV  output  1  signed overflow. Set when the MSB carry-in differs from the MSB carry-out.

Behaviour:
- One clock (clk). Reset (rst) is synchronous and active-high. All state, including outputs, changes only on the rising edge of clk.
- Reset: every stage valid bit is cleared. Y=0, CB=0, OV=0, out_valid=0. in_ready is 1 in the cycle after reset is released. Any beat in flight is discarded when rst is asserted mid-operation. rst has priority over all other inputs.
- Pipeline: STAGES register stages, each with a valid bit.
  - Stage 0 captures A, B and sub. It applies the B inversion when sub=1, and its carry-in is sub.
  - Stage k (k=0..STAGES-1) adds slice k (bits k*CHUNK+CHUNK-1 .. k*CHUNK) with the registered carry from stage k-1. Stage 0 uses sub as its carry-in.
  - Not-yet-processed upper operand slices and already-computed lower result slices are carried forward (skewed) alongside each beat.
- Advance condition: adv = !out_valid || out_ready. The whole pipeline moves one stage when adv=1 and holds every register when adv=0. Bubbles (valid=0) still move.
- in_ready = adv, a combinational function of out_valid and out_ready. A beat is accepted when in_valid && in_ready.
- Latency: a beat accepted at edge n appears on Y/CB/OV with out_valid=1 after edge n+STAGES-1, provided adv=1 throughout. Each stall cycle adds one cycle.
- Throughput: one beat per cycle when out_ready is held at 1.
- Output hold: while out_valid=1 and out_ready=0, Y/CB/OV/out_valid stay stable and the pipeline is frozen.
- Simultaneous events:
  - A new input is accepted in the same cycle the output is consumed.
  - in_valid=1 with in_ready=0 is not captured; the source must hold it.
- Flags:
  - CB is the carry out of the top slice.
  - OV = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - Both flags are registered with Y and are valid only when out_valid=1.
- Results are bit-identical to the combinational adder's Y/CB for sub=0.
- Degenerate case: CHUNK=WIDTH gives STAGES=1 and a single-cycle registered adder.

Test Plan:
1. Reset then single add, defaults: A=0xFFFFFFFF, B=0x00000001, sub=0. Expect out_valid exactly 4 cycles after acceptance, Y=0x00000000, CB=1, OV=0. This exercises the carry ripple across all 4 stages.
2. Subtract with borrow: A=0x00000005, B=0x00000007, sub=1 -> Y=0xFFFFFFFE, CB=0, OV=0. Then A=0x80000000, B=0x00000001, sub=1 -> Y=0x7FFFFFFF, CB=1, OV=1.
3. Signed add overflow: A=0x7FFFFFFF, B=0x00000001, sub=0 -> Y=0x80000000, CB=0, OV=1.
4. Streaming with backpressure: 20 back-to-back random beats, with out_ready toggled as 1,1,0,0,0,1,... Expect every result in order, matching a reference A±B model, with no loss or duplication. During stalls Y must be stable and in_ready=0.
5. Reset mid-stream: assert rst for 1 cycle with 3 beats in flight. Expect out_valid=0, Y=0, CB=0, OV=0 the next cycle and no stale beat emerging afterwards. The next accepted beat appears with nominal latency.
6. Parameter sweep: WIDTH=16/CHUNK=4 and WIDTH=8/CHUNK=8. Expect latency of 4 and 1 cycles respectively. A=0x00FF+B=0xFF01 (WIDTH=16) -> Y=0x0000, CB=1.
